// File: rtl/keypad_encoder_sync.sv
// Clocked keypad encoder for the microwave front panel.
// Synchronises and debounces raw one-hot keypad lines, then emits one key code
// with a one-cycle active-low load strobe per accepted press. Multi-key presses
// are rejected, and a key that stays held never repeats.
module keypad_encoder_sync #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [CODE_W-1:0]   D,
  output logic                loadn,
  output logic                busy,
  output logic                err_multi
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LOAD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // The count that closes a debounce interval. A press starts at 1, so this
  // value is reached after DEBOUNCE_CYCLES matching samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NUM_KEYS-1:0] snap, snap_n;
  logic [CODE_W-1:0]   code_n;
  logic                loadn_n;
  logic                err_n;
  logic [NUM_KEYS-1:0] sync_p0, sync_p1;
  logic [NUM_KEYS-1:0] kp_s;

  // Returns the index of the highest set bit. The caller ensures that exactly
  // one bit is set.
  function automatic logic [CODE_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (v[k]) idx = CODE_W'(k);
    end
    return idx;
  endfunction

  // True when exactly one key line is active.
  function automatic logic one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  assign kp_s = sync_p1;
  assign busy = (state != IDLE);

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= keypad;
      sync_p1 <= sync_p0;
    end
  end

  // State, debounce counter, snapshot and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      snap      <= '0;
      D         <= '0;
      loadn     <= 1'b1;
      err_multi <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      snap      <= snap_n;
      D         <= code_n;
      loadn     <= loadn_n;
      err_multi <= err_n;
    end
  end

  // Next-state and next-output logic. A high enablen overrides every transition.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    code_n  = D;
    loadn_n = 1'b1;
    err_n   = err_multi;
    if (enablen) begin
      state_n = IDLE;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kp_s != '0) begin
            state_n = DEBOUNCE;
            snap_n  = kp_s;
            cnt_n   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (kp_s == snap) begin
            if (cnt == CNT_LAST) begin
              if (one_hot(snap)) begin
                state_n = LOAD;
                code_n  = encode(snap);
                loadn_n = 1'b0;
              end else begin
                state_n = WAIT_RELEASE;
                err_n   = 1'b1;
                cnt_n   = '0;
              end
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (kp_s == '0) begin
            state_n = IDLE;
          end else begin
            snap_n = kp_s;
            cnt_n  = CNT_W'(1);
          end
        end
        LOAD: begin
          state_n = WAIT_RELEASE;
          cnt_n   = '0;
        end
        WAIT_RELEASE: begin
          if (kp_s == '0) begin
            if (cnt == CNT_LAST) begin
              state_n = IDLE;
              err_n   = 1'b0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder_sync.sv
// Directed bench for keypad_encoder_sync with the default parameters.
// Inputs change 1 ns after a rising edge, and outputs are checked at the same
// point. Edge n is the n-th rising edge after the keypad value changed.
module tb_keypad_encoder_sync;

  logic       clk;
  logic       resetn;
  logic [9:0] keypad;
  logic       enablen;
  logic [3:0] D;
  logic       loadn;
  logic       busy;
  logic       err_multi;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  int base;

  keypad_encoder_sync #(
    .NUM_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .CNT_W(3)
  ) dut (
    .clk(clk), .resetn(resetn), .keypad(keypad), .enablen(enablen),
    .D(D), .loadn(loadn), .busy(busy), .err_multi(err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles, sampling in the middle of the clock period.
  always @(negedge clk) begin
    if (!loadn) strobes++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn  = 1'b0;
    keypad  = '0;
    enablen = 1'b0;
    step(2);
    check_eq("rst_D", 32'(D), 0);
    check_eq("rst_loadn", 32'(loadn), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err_multi), 0);
    resetn = 1'b1;
    step(2);

    // Clean single press of key 9.
    base   = strobes;
    keypad = 10'b1000000000;
    step(5);
    check_eq("clean_e5_loadn", 32'(loadn), 1);
    step(1);
    check_eq("clean_e6_loadn", 32'(loadn), 0);
    check_eq("clean_e6_D", 32'(D), 9);
    step(1);
    check_eq("clean_e7_loadn", 32'(loadn), 1);
    check_eq("clean_e7_busy", 32'(busy), 1);
    step(13);
    keypad = '0;
    step(5);
    check_eq("clean_rel5_busy", 32'(busy), 1);
    step(1);
    check_eq("clean_rel6_busy", 32'(busy), 0);
    check_eq("clean_strobes", 32'(strobes - base), 1);
    check_eq("clean_D_hold", 32'(D), 9);

    // Bouncing key 2 settles after six toggles.
    base = strobes;
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'b0000000100 : 10'b0000000000;
      step(1);
    end
    keypad = 10'b0000000100;
    step(5);
    check_eq("bounce_nostrobe", 32'(strobes - base), 0);
    check_eq("bounce_e5_loadn", 32'(loadn), 1);
    step(1);
    check_eq("bounce_e6_loadn", 32'(loadn), 0);
    check_eq("bounce_e6_D", 32'(D), 2);
    step(4);
    keypad = '0;
    step(8);
    check_eq("bounce_strobes", 32'(strobes - base), 1);
    check_eq("bounce_idle", 32'(busy), 0);

    // Two keys at once are rejected.
    base   = strobes;
    keypad = 10'b0000000101;
    step(10);
    check_eq("multi_err", 32'(err_multi), 1);
    check_eq("multi_busy", 32'(busy), 1);
    check_eq("multi_D", 32'(D), 2);
    check_eq("multi_nostrobe", 32'(strobes - base), 0);
    keypad = '0;
    step(5);
    check_eq("multi_rel5_err", 32'(err_multi), 1);
    step(1);
    check_eq("multi_rel6_err", 32'(err_multi), 0);
    check_eq("multi_rel6_busy", 32'(busy), 0);
    keypad = 10'b0000000001;
    step(6);
    check_eq("key0_loadn", 32'(loadn), 0);
    check_eq("key0_D", 32'(D), 0);
    keypad = '0;
    step(8);
    check_eq("key0_strobes", 32'(strobes - base), 1);

    // A held key strobes once; a fresh press after a short release strobes again.
    base   = strobes;
    keypad = 10'b0000100000;
    step(100);
    check_eq("hold_strobes", 32'(strobes - base), 1);
    check_eq("hold_D", 32'(D), 5);
    check_eq("hold_busy", 32'(busy), 1);
    keypad = '0;
    step(4);
    keypad = 10'b0000100000;
    step(10);
    check_eq("repeat_strobes", 32'(strobes - base), 2);
    check_eq("repeat_D", 32'(D), 5);
    keypad = '0;
    step(8);

    // enablen gating.
    base    = strobes;
    enablen = 1'b1;
    keypad  = 10'b0000000100;
    step(10);
    check_eq("en_nostrobe", 32'(strobes - base), 0);
    check_eq("en_busy", 32'(busy), 0);
    enablen = 1'b0;
    step(4);
    check_eq("en_drop_loadn", 32'(loadn), 0);
    check_eq("en_drop_D", 32'(D), 2);
    step(2);
    check_eq("en_drop_strobes", 32'(strobes - base), 1);
    keypad = '0;
    step(8);
    keypad = 10'b0010000000;
    step(4);
    check_eq("en_abort_pre_busy", 32'(busy), 1);
    enablen = 1'b1;
    step(1);
    check_eq("en_abort_busy", 32'(busy), 0);
    step(6);
    check_eq("en_abort_strobes", 32'(strobes - base), 1);
    check_eq("en_abort_D", 32'(D), 2);
    keypad  = '0;
    enablen = 1'b0;
    step(8);

    // Asynchronous reset in the middle of a debounce.
    base   = strobes;
    keypad = 10'b0000001000;
    step(4);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_D", 32'(D), 0);
    check_eq("arst_loadn", 32'(loadn), 1);
    check_eq("arst_busy", 32'(busy), 0);
    step(1);
    resetn = 1'b1;
    step(5);
    check_eq("arst_e5_loadn", 32'(loadn), 1);
    step(1);
    check_eq("arst_e6_loadn", 32'(loadn), 0);
    check_eq("arst_e6_D", 32'(D), 3);
    keypad = '0;
    step(8);
    check_eq("arst_strobes", 32'(strobes - base), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
